// File: rtl/adder_share_arbiter.sv
// adder_share_arbiter
//   Shares a single adder_8_bits instance between two clients. One client is
//   granted at a time. Its operands are registered into the adder, and the
//   registered sum/overflow comes back tagged with the client id.
//
//   Ports:
//     clk, rst            rising-edge clock, async active-high reset
//     req0/a0/b0, gnt0    client 0 request (level), operands, grant pulse
//     req1/a1/b1, gnt1    client 1 request (level), operands, grant pulse
//     res_valid           one-cycle result strobe
//     res_id              owner of the result (valid from the grant cycle)
//     res_sum, res_ovf    registered sum and two's-complement overflow
//
//   Operand bit numbering is [1:8], where bit 1 is the MSB.
//
//   Build option: ADDER_ARB_FIXED_PRIO_EN
//     Defined:   client 0 always wins contention.
//     Undefined: round-robin arbitration using the last-winner pointer.

module adder_8_bits (
  output logic [1:8] sum,
  output logic       ovf,
  input  logic [1:8] x,
  input  logic [1:8] y
);
  assign sum = x + y;
  // Signed overflow: the operands share a sign, but the result sign differs.
  assign ovf = (x[1] == y[1]) && (sum[1] != x[1]);
endmodule

module adder_share_arbiter (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic [1:8] a0,
  input  logic [1:8] b0,
  output logic       gnt0,
  input  logic       req1,
  input  logic [1:8] a1,
  input  logic [1:8] b1,
  output logic       gnt1,
  output logic       res_valid,
  output logic       res_id,
  output logic [1:8] res_sum,
  output logic       res_ovf
);
  localparam logic IDLE = 1'b0;
  localparam logic EXEC = 1'b1;

  logic       state;
  logic       win;
  logic [1:8] opa, opb;
  logic [1:8] add_sum;
  logic       add_ovf;

  adder_8_bits u_add (
    .sum (add_sum),
    .ovf (add_ovf),
    .x   (opa),
    .y   (opb)
  );

`ifdef ADDER_ARB_FIXED_PRIO_EN
  // Client 0 wins whenever it requests. win is only used when a request is present.
  always_comb win = ~req0;
`else
  logic last;

  // Under contention the client that did not win last time is chosen.
  always_comb begin
    win = req1;
    if (req0 && req1) win = ~last;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                              last <= 1'b1;
    else if (state == IDLE && (req0 || req1)) last <= win;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      gnt0      <= 1'b0;
      gnt1      <= 1'b0;
      res_valid <= 1'b0;
      res_id    <= 1'b0;
      res_sum   <= '0;
      res_ovf   <= 1'b0;
      opa       <= '0;
      opb       <= '0;
    end else begin
      case (state)
        IDLE: begin
          res_valid <= 1'b0;
          if (req0 || req1) begin
            opa    <= win ? a1 : a0;
            opb    <= win ? b1 : b0;
            gnt0   <= ~win;
            gnt1   <= win;
            res_id <= win;
            state  <= EXEC;
          end
        end
        default: begin
          // Requests are ignored here. The adder output settles from opa/opb.
          gnt0      <= 1'b0;
          gnt1      <= 1'b0;
          res_sum   <= add_sum;
          res_ovf   <= add_ovf;
          res_valid <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_adder_share_arbiter.sv
module tb_adder_share_arbiter;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       req0 = 1'b0, req1 = 1'b0;
  logic [7:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic       gnt0, gnt1, res_valid, res_id, res_ovf;
  logic [7:0] res_sum;

  adder_share_arbiter dut (
    .clk(clk), .rst(rst),
    .req0(req0), .a0(a0), .b0(b0), .gnt0(gnt0),
    .req1(req1), .a1(a1), .b1(b1), .gnt1(gnt1),
    .res_valid(res_valid), .res_id(res_id), .res_sum(res_sum), .res_ovf(res_ovf)
  );

  always #5 clk = ~clk;

  typedef struct { bit id; logic [7:0] sum; bit ovf; } res_t;

  int   total = 0;
  int   bad   = 0;
  bit   mon_en = 0;
  bit   mlast = 1'b1;
  bit   gq[$];
  res_t rq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic bit pick(input bit p0, input bit p1);
`ifdef ADDER_ARB_FIXED_PRIO_EN
    return p0 ? 1'b0 : 1'b1;
`else
    if (p0 && p1) return ~mlast;
    return p1;
`endif
  endfunction

  function automatic res_t ref_add(input bit id, input logic [7:0] x, input logic [7:0] y);
    res_t r;
    int sx, sy, s;
    sx = int'($signed(x));
    sy = int'($signed(y));
    s = sx + sy;
    r.id  = id;
    r.sum = 8'((int'(x) + int'(y)) % 256);
    r.ovf = (s > 127) || (s < -128);
    return r;
  endfunction

  // Scoreboard monitor
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      chk("gnt_excl", {31'b0, gnt0 & gnt1}, 0);
      chk("gnt_vs_valid", {31'b0, res_valid & (gnt0 | gnt1)}, 0);
      if (gnt0 || gnt1) begin
        if (gq.size() == 0) chk("gnt_unexpected", 1, 0);
        else begin
          bit e;
          e = gq.pop_front();
          chk("gnt_id", {31'b0, gnt1}, {31'b0, e});
          chk("res_id_at_gnt", {31'b0, res_id}, {31'b0, e});
        end
      end
      if (res_valid) begin
        if (rq.size() == 0) chk("res_unexpected", 1, 0);
        else begin
          res_t e;
          e = rq.pop_front();
          chk("res_id", {31'b0, res_id}, {31'b0, e.id});
          chk("res_sum", {24'b0, res_sum}, {24'b0, e.sum});
          chk("res_ovf", {31'b0, res_ovf}, {31'b0, e.ovf});
        end
      end
    end
  end

  // Wait for a grant. The grant is expected at the very next falling edge.
  task automatic wait_gnt(output bit got);
    got = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (gnt0 || gnt1) begin
        got = 1;
        chk("gnt_latency", k, 0);
        break;
      end
    end
    if (!got) chk("gnt_timeout", 0, 1);
  endtask

  // Requesters follow the protocol: each drops its request in its grant cycle.
  task automatic do_round(input bit p0i, input logic [7:0] x0, input logic [7:0] y0,
                          input bit p1i, input logic [7:0] x1, input logic [7:0] y1);
    bit p0, p1, w, got;
    p0 = p0i; p1 = p1i;
    req0 = p0; a0 = x0; b0 = y0;
    req1 = p1; a1 = x1; b1 = y1;
    while (p0 || p1) begin
      w = pick(p0, p1);
      gq.push_back(w);
      rq.push_back(w ? ref_add(1'b1, x1, y1) : ref_add(1'b0, x0, y0));
      mlast = w;
      wait_gnt(got);
      if (!got) begin req0 = 0; req1 = 0; break; end
      if (w) begin p1 = 0; req1 = 0; end
      else   begin p0 = 0; req0 = 0; end
      @(negedge clk);
      chk("res_latency", {31'b0, res_valid}, 1);
    end
  endtask

  // Both requests are held high through n operations.
  task automatic contention(input int n);
    bit w, got;
    req0 = 1; a0 = 8'h11; b0 = 8'h22;
    req1 = 1; a1 = 8'h70; b1 = 8'h10;
    for (int i = 0; i < n; i++) begin
      w = pick(1, 1);
      gq.push_back(w);
      rq.push_back(w ? ref_add(1'b1, 8'h70, 8'h10) : ref_add(1'b0, 8'h11, 8'h22));
      mlast = w;
      wait_gnt(got);
      if (!got) break;
      @(negedge clk);
      chk("cont_res_latency", {31'b0, res_valid}, 1);
    end
    req0 = 0; req1 = 0;
  endtask

  initial begin
    bit got;
    // Asynchronous reset taking effect mid-cycle
    @(posedge clk); #2 rst = 1;
    #1;
    chk("rst_gnt0", {31'b0, gnt0}, 0);
    chk("rst_gnt1", {31'b0, gnt1}, 0);
    chk("rst_valid", {31'b0, res_valid}, 0);
    chk("rst_id", {31'b0, res_id}, 0);
    chk("rst_sum", {24'b0, res_sum}, 0);
    chk("rst_ovf", {31'b0, res_ovf}, 0);
    @(negedge clk); rst = 0; mon_en = 1; mlast = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_outs", {22'b0, gnt0, gnt1, res_valid, res_sum, res_ovf}, 0);
    end

    // Single client
    do_round(1, 8'h05, 8'h03, 0, 8'h00, 8'h00);
    // Overflow corners through client 1
    do_round(0, 8'h00, 8'h00, 1, 8'h7F, 8'h01);
    do_round(0, 8'h00, 8'h00, 1, 8'h80, 8'h80);
    do_round(0, 8'h00, 8'h00, 1, 8'hFF, 8'h01);
    do_round(0, 8'h00, 8'h00, 1, 8'h00, 8'h00);
    repeat (2) @(negedge clk);

    // Contention: six back-to-back grants
    contention(6);
    @(negedge clk);

    // Back-to-back: the new request is raised during the res_valid cycle
    do_round(1, 8'h01, 8'h02, 0, 8'h00, 8'h00);
    do_round(1, 8'h10, 8'h20, 0, 8'h00, 8'h00);

    // Randomized rounds
    for (int i = 0; i < 24; i++) begin
      bit p0, p1;
      p0 = 1'($urandom);
      p1 = p0 ? 1'($urandom) : 1'b1;
      do_round(p0, 8'($urandom), 8'($urandom), p1, 8'($urandom), 8'($urandom));
      if ($urandom_range(0, 2) == 0) @(negedge clk);
    end
    repeat (2) @(negedge clk);

    // Reset mid-operation: move the pointer to 0, then abort a client-0 operation
    do_round(1, 8'h01, 8'h01, 0, 8'h00, 8'h00);
    req0 = 1; a0 = 8'h40; b0 = 8'h40;
    gq.push_back(1'b0);
    wait_gnt(got);
    chk("abort_gnt0", {31'b0, gnt0}, 1);
    #2 rst = 1; req0 = 0;
    mlast = 1;
    #1;
    chk("abort_gnt0_clr", {31'b0, gnt0}, 0);
    chk("abort_valid_clr", {31'b0, res_valid}, 0);
    @(negedge clk); rst = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("abort_no_valid", {31'b0, res_valid}, 0);
    end
    do_round(1, 8'h33, 8'h44, 1, 8'h55, 8'h66);
    repeat (3) @(negedge clk);

    chk("gq_empty", gq.size(), 0);
    chk("rq_empty", rq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout act=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
